// File: rtl/dim_pole_pkg.sv
// Shared constants, channel-width helper and pipeline record for the dim-pole delay line.
package dim_pole_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 7;
  localparam int MAX_CH_W   = 16;

  function automatic int ch_w_f(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  typedef enum logic {
    CH_FILLING = 1'b0,
    CH_PRIMED  = 1'b1
  } chan_state_e;

  // Stage-1 record; chan is sized for the widest supported channel index
  typedef struct packed {
    logic                valid;
    logic [MAX_CH_W-1:0] chan;
    logic                primed;
  } s1_rec_t;

endpackage

// File: rtl/dim_pole_ram.sv
// Simple dual-port RAM with one write port and one registered read port (1-cycle latency).
module dim_pole_ram #(
  parameter int DATA_W = 16,
  parameter int AW     = 9,
  parameter int DEPTH  = 512
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dim_pole_delay_line.sv
// Multi-channel circular delay line: returns the sample written D samples earlier on the
// same channel, or zero until that channel has accumulated D samples.
module dim_pole_delay_line
  import dim_pole_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NCH    = 4,
  localparam int CH_W  = ch_w_f(NCH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic [ADDR_W-1:0] delay,
  input  logic              in_valid,
  input  logic [CH_W-1:0]   in_chan,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [CH_W-1:0]   out_chan,
  output logic [DATA_W-1:0] out_data,
  output logic              out_primed
);

  localparam int AW    = CH_W + ADDR_W;
  localparam int DEPTH = NCH << ADDR_W;

  logic [ADDR_W-1:0] delay_q;
  logic [ADDR_W-1:0] delay_eff;
  logic              flush;
  logic              chan_ok;
  logic              accept;
  logic [ADDR_W-1:0] ptr_arr   [NCH];
  chan_state_e       state_arr [NCH];
  logic [ADDR_W-1:0] cur_ptr;
  logic              cur_primed;
  logic [ADDR_W-1:0] rd_ptr;
  logic [AW-1:0]     wr_addr;
  logic [AW-1:0]     rd_addr;
  logic [DATA_W-1:0] ram_rdata;
  s1_rec_t           s1_q;

  assign delay_eff = (delay == '0) ? ADDR_W'(1) : delay;
  assign flush     = reset | clear;
  assign chan_ok   = (32'(in_chan) < 32'(NCH));
  assign accept    = in_valid & chan_ok & ~flush;

  always_ff @(posedge clock) begin
    if (flush) delay_q <= delay_eff;
  end

  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
      logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
      logic [ADDR_W-1:0] fill_q, fill_d;
      chan_state_e       state_q, state_d;
      logic              hit;

      assign hit = accept && (in_chan == CH_W'(gi));

      always_comb begin
        wr_ptr_d = wr_ptr_q;
        fill_d   = fill_q;
        state_d  = state_q;
        if (hit) begin
          wr_ptr_d = wr_ptr_q + 1'b1;
          if (fill_q < delay_q) fill_d = fill_q + 1'b1;
          if (state_q == CH_FILLING && fill_d == delay_q) state_d = CH_PRIMED;
        end
      end

      always_ff @(posedge clock) begin
        if (flush) begin
          wr_ptr_q <= '0;
          fill_q   <= '0;
          state_q  <= CH_FILLING;
        end else begin
          wr_ptr_q <= wr_ptr_d;
          fill_q   <= fill_d;
          state_q  <= state_d;
        end
      end

      assign ptr_arr[gi]   = wr_ptr_q;
      assign state_arr[gi] = state_q;
    end
  endgenerate

  always_comb begin
    cur_ptr    = '0;
    cur_primed = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (in_chan == CH_W'(i)) begin
        cur_ptr    = ptr_arr[i];
        cur_primed = (state_arr[i] == CH_PRIMED);
      end
    end
  end

  // delay_q >= 1, so the read slot is never the slot being written this cycle
  assign rd_ptr  = cur_ptr - delay_q;
  assign wr_addr = {in_chan, cur_ptr};
  assign rd_addr = {in_chan, rd_ptr};

  dim_pole_ram #(
    .DATA_W (DATA_W),
    .AW     (AW),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk     (clock),
    .we_i    (accept),
    .waddr_i (wr_addr),
    .wdata_i (in_data),
    .re_i    (accept),
    .raddr_i (rd_addr),
    .rdata_o (ram_rdata)
  );

  always_ff @(posedge clock) begin
    if (flush) begin
      s1_q <= '0;
    end else begin
      s1_q.valid  <= accept;
      s1_q.chan   <= MAX_CH_W'(in_chan);
      s1_q.primed <= cur_primed;
    end
  end

  // Stale RAM contents are hidden here until the channel is primed
  always_ff @(posedge clock) begin
    if (flush) begin
      out_valid  <= 1'b0;
      out_chan   <= '0;
      out_data   <= '0;
      out_primed <= 1'b0;
    end else begin
      out_valid <= s1_q.valid;
      if (s1_q.valid) begin
        out_chan   <= CH_W'(s1_q.chan);
        out_data   <= s1_q.primed ? ram_rdata : '0;
        out_primed <= s1_q.primed;
      end
    end
  end

endmodule

// File: tb/tb_dim_pole_delay_line.sv
// Scoreboard bench: drivers push hand-computed expectations, a negedge monitor pops and checks.
module tb_dim_pole_delay_line;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 7;
  localparam int NCH    = 3;
  localparam int CH_W   = 2;

  logic              clock = 1'b0;
  logic              reset;
  logic              clear;
  logic [ADDR_W-1:0] delay;
  logic              in_valid;
  logic [CH_W-1:0]   in_chan;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic [CH_W-1:0]   out_chan;
  logic [DATA_W-1:0] out_data;
  logic              out_primed;

  typedef struct {
    int ch;
    int d;
    bit p;
    int c;
  } exp_t;

  exp_t exp_q[$];
  int   cyc    = 0;
  int   tests  = 0;
  int   failed = 0;

  dim_pole_delay_line #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .NCH    (NCH)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .clear      (clear),
    .delay      (delay),
    .in_valid   (in_valid),
    .in_chan    (in_chan),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_chan   (out_chan),
    .out_data   (out_data),
    .out_primed (out_primed)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc++;

  // Monitor: every presented output must match the head of the scoreboard
  always @(negedge clock) begin
    if (out_valid) begin
      tests++;
      if (exp_q.size() == 0) begin
        failed++;
        $display("FAIL unexpected_out cyc=%0d ch=%0d data=%0d primed=%0d required=no output",
                 cyc, out_chan, out_data, out_primed);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (out_chan != CH_W'(e.ch) || out_data != DATA_W'(e.d) || out_primed != e.p || cyc != e.c) begin
          failed++;
          $display("FAIL out_txn cyc=%0d/%0d ch=%0d/%0d data=%0d/%0d primed=%0d/%0d (actual/required)",
                   cyc, e.c, out_chan, e.ch, out_data, e.d, out_primed, e.p);
        end else begin
          $display("[TB] out cyc=%0d ch=%0d data=%0d primed=%0d ok", cyc, out_chan, out_data, out_primed);
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      failed++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end else begin
      $display("[TB] check %s = %0d ok", name, act);
    end
  endtask

  task automatic send(input int ch, input int d, input bit exp_en, input int exp_d, input bit exp_p);
    exp_t e;
    @(posedge clock); #1;
    reset    = 1'b0;
    clear    = 1'b0;
    in_valid = 1'b1;
    in_chan  = CH_W'(ch);
    in_data  = DATA_W'(d);
    if (exp_en) begin
      e.ch = ch; e.d = exp_d; e.p = exp_p; e.c = cyc + 2;
      exp_q.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock); #1;
      reset    = 1'b0;
      clear    = 1'b0;
      in_valid = 1'b0;
    end
  endtask

  task automatic clear_pulse(input int new_delay);
    @(posedge clock); #1;
    delay    = ADDR_W'(new_delay);
    clear    = 1'b1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    idle(1);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clock);
    check(name, exp_q.size(), 0);
    idle(2);
  endtask

  initial begin
    reset    = 1'b1;
    clear    = 1'b0;
    delay    = 7'd3;
    in_valid = 1'b0;
    in_chan  = '0;
    in_data  = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_out_chan", int'(out_chan), 0);
    check("reset_out_data", int'(out_data), 0);
    check("reset_out_primed", int'(out_primed), 0);

    // Basic delay 3 on ch0; a delay change mid-stream must be ignored
    send(0, 1, 1, 0, 0);
    send(0, 2, 1, 0, 0);
    delay = 7'd5;
    send(0, 3, 1, 0, 0);
    send(0, 4, 1, 1, 1);
    send(0, 5, 1, 2, 1);
    send(0, 6, 1, 3, 1);
    drain("basic_drain");

    // Interleaved ch0/ch1, delay 2
    clear_pulse(2);
    send(0, 10, 1, 0, 0);
    send(1, 20, 1, 0, 0);
    send(0, 11, 1, 0, 0);
    send(1, 21, 1, 0, 0);
    send(0, 12, 1, 10, 1);
    send(1, 22, 1, 20, 1);
    drain("interleave_drain");

    // Wrap-around on ch2 with maximum delay
    clear_pulse(127);
    for (int n = 0; n < 300; n++)
      send(2, n, 1, (n < 127) ? 0 : n - 127, n >= 127);
    drain("wrap_drain");

    // Mid-stream clear with a concurrent sample; new delay latched by the clear
    clear_pulse(2);
    send(0, 1, 1, 0, 0);
    send(0, 2, 1, 0, 0);
    send(0, 3, 1, 1, 1);
    send(0, 4, 1, 2, 1);
    delay = 7'd3;
    send(0, 5, 0, 0, 0);
    send(0, 6, 0, 0, 0);
    clear = 1'b1;
    send(0, 7, 1, 0, 0);
    delay = 7'd1;
    send(0, 8, 1, 0, 0);
    send(0, 9, 1, 0, 0);
    send(0, 10, 1, 7, 1);
    drain("clear_drain");

    // Reset mid-stream on ch1; reset latches delay 0 -> treated as 1
    send(1, 100, 1, 0, 0);
    send(1, 101, 1, 0, 0);
    send(1, 102, 1, 0, 0);
    send(1, 103, 0, 0, 0);
    @(posedge clock); #1;
    reset    = 1'b1;
    in_valid = 1'b0;
    delay    = 7'd0;
    @(posedge clock);
    @(negedge clock);
    check("midreset_out_valid", int'(out_valid), 0);
    check("midreset_out_chan", int'(out_chan), 0);
    check("midreset_out_data", int'(out_data), 0);
    check("midreset_out_primed", int'(out_primed), 0);
    idle(1);
    @(negedge clock);
    check("postreset_out_valid", int'(out_valid), 0);
    send(0, 7, 1, 0, 0);
    send(0, 8, 1, 7, 1);

    // Out-of-range channel: no output, no effect on real channels
    send(3, 55, 0, 0, 0);
    send(0, 9, 1, 8, 1);
    send(2, 40, 1, 0, 0);
    send(2, 41, 1, 40, 1);
    drain("final_drain");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
